calendar_sequencer: RTL and testbench

CALENDAR_SEQUENCER -- requirements
Module: calendar_sequencer

---
 rtl/calendar_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_calendar_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/calendar_sequencer.sv
// Calendar date sequencer: day-tick advance with leap years and a checked date-load FSM.
// Optional weekday tracking is built when CALENDAR_WEEKDAY_EN is defined.
module calendar_sequencer #(
  parameter int YEAR_MAX = 974
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_day,
  input  logic [3:0] set_month,
  input  logic [9:0] set_year,
`ifdef CALENDAR_WEEKDAY_EN
  input  logic [2:0] set_wday,
  output logic [2:0] weekday,
`endif
  output logic       set_done,
  output logic       set_err,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [9:0] year,
  output logic       year_wrap,
  output logic       tick_overrun
);

  localparam logic [9:0] YMAX = 10'(YEAR_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_COMMIT} state_t;

  typedef struct packed {
    logic [4:0] d;
    logic [3:0] m;
    logic [9:0] y;
  } date_t;

  state_t r_state;
  date_t  r_date;
  date_t  r_ld;
  logic   r_pend;
  logic   r_done;
  logic   r_err;
  logic   r_wrap;
  logic   r_ovr;

  date_t      w_nxt;
  logic       w_wrap;
  logic [4:0] w_len_cur;
  logic [4:0] w_len_ld;
  logic [4:0] w_ld_day;
  logic       w_ld_bad;

`ifdef CALENDAR_WEEKDAY_EN
  logic [2:0] r_wday;
  logic [2:0] r_ld_wday;
  logic [2:0] w_wday_nxt;
`endif

  // Year is an offset from 2025; the Gregorian leap rule works on the absolute year.
  function automatic logic [4:0] f_mlen(input logic [3:0] m, input logic [9:0] y);
    logic [11:0] fy;
    logic        leap;
    fy   = 12'd2025 + {2'b00, y};
    leap = (fy[1:0] == 2'b00) &&
           (((fy % 12'd100) != 12'd0) || ((fy % 12'd400) == 12'd0));
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: f_mlen = 5'd30;
      4'd2:                    f_mlen = leap ? 5'd29 : 5'd28;
      default:                 f_mlen = 5'd31;
    endcase
  endfunction

  always_comb begin
    w_len_cur = f_mlen(r_date.m, r_date.y);
    w_nxt     = r_date;
    w_wrap    = 1'b0;
    if (r_date.d < w_len_cur) begin
      w_nxt.d = r_date.d + 5'd1;
    end else begin
      w_nxt.d = 5'd1;
      if (r_date.m == 4'd12) begin
        w_nxt.m = 4'd1;
        if (r_date.y >= YMAX) begin
          w_nxt.y = 10'd0;
          w_wrap  = 1'b1;
        end else begin
          w_nxt.y = r_date.y + 10'd1;
        end
      end else begin
        w_nxt.m = r_date.m + 4'd1;
      end
    end
  end

  always_comb begin
    w_len_ld = f_mlen(r_ld.m, r_ld.y);
    w_ld_day = (r_ld.d > w_len_ld) ? w_len_ld : r_ld.d;
    w_ld_bad = (r_ld.m == 4'd0) || (r_ld.m > 4'd12) || (r_ld.d == 5'd0) || (r_ld.y > YMAX);
`ifdef CALENDAR_WEEKDAY_EN
    if (r_ld_wday > 3'd6) w_ld_bad = 1'b1;
    w_wday_nxt = (r_wday == 3'd6) ? 3'd0 : r_wday + 3'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_date  <= '{d: 5'd1, m: 4'd1, y: 10'd0};
      r_ld    <= '{d: 5'd1, m: 4'd1, y: 10'd0};
      r_pend  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef CALENDAR_WEEKDAY_EN
      r_wday    <= 3'd3;
      r_ld_wday <= 3'd3;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
      r_ovr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            // Deferred tick goes first; a fresh tick this cycle re-arms the slot.
            r_date <= w_nxt;
            r_wrap <= w_wrap;
            r_pend <= day_tick;
`ifdef CALENDAR_WEEKDAY_EN
            r_wday <= w_wday_nxt;
`endif
          end else begin
            if (day_tick) begin
              r_date <= w_nxt;
              r_wrap <= w_wrap;
`ifdef CALENDAR_WEEKDAY_EN
              r_wday <= w_wday_nxt;
`endif
            end
            if (set_valid) begin
              r_ld    <= '{d: set_day, m: set_month, y: set_year};
              r_state <= ST_CHECK;
`ifdef CALENDAR_WEEKDAY_EN
              r_ld_wday <= set_wday;
`endif
            end
          end
        end
        ST_CHECK: begin
          if (day_tick) begin
            if (r_pend) r_ovr  <= 1'b1;
            else        r_pend <= 1'b1;
          end
          if (w_ld_bad) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_ld.d  <= w_ld_day;
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (day_tick) begin
            if (r_pend) r_ovr  <= 1'b1;
            else        r_pend <= 1'b1;
          end
          r_date  <= r_ld;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
`ifdef CALENDAR_WEEKDAY_EN
          r_wday <= r_ld_wday;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign set_ready    = (r_state == ST_IDLE) && !r_pend;
  assign set_done     = r_done;
  assign set_err      = r_err;
  assign day          = r_date.d;
  assign month        = r_date.m;
  assign year         = r_date.y;
  assign year_wrap    = r_wrap;
  assign tick_overrun = r_ovr;
`ifdef CALENDAR_WEEKDAY_EN
  assign weekday      = r_wday;
`endif

endmodule

// File: tb/tb_calendar_sequencer.sv
// Scoreboard bench for calendar_sequencer: stimulus queues expected events, a monitor
// pops one entry whenever the date changes or any status pulse appears.
module tb_calendar_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       day_tick = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_day = '0;
  logic [3:0] set_month = '0;
  logic [9:0] set_year = '0;
  logic       set_ready, set_done, set_err, year_wrap, tick_overrun;
  logic [4:0] day;
  logic [3:0] month;
  logic [9:0] year;
`ifdef CALENDAR_WEEKDAY_EN
  logic [2:0] set_wday = 3'd0;
  logic [2:0] weekday;
`endif

  calendar_sequencer #(.YEAR_MAX(974)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
`ifdef CALENDAR_WEEKDAY_EN
    .set_wday(set_wday), .weekday(weekday),
`endif
    .set_done(set_done), .set_err(set_err),
    .day(day), .month(month), .year(year),
    .year_wrap(year_wrap), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] d;
    logic [3:0] m;
    logic [9:0] y;
    logic       done;
    logic       err;
    logic       wrap;
    logic       ovr;
    logic       rdy;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [18:0] prev;
  ev_t         act_ev;
  ev_t         exp_ev;

  function automatic ev_t mk(input int d, input int m, input int y, input bit done,
                             input bit err, input bit wrap, input bit ovr, input bit rdy);
    ev_t e;
    e.d = 5'(d); e.m = 4'(m); e.y = 10'(y);
    e.done = done; e.err = err; e.wrap = wrap; e.ovr = ovr; e.rdy = rdy;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      act_ev = {day, month, year, set_done, set_err, year_wrap, tick_overrun, set_ready};
      if (set_done || set_err || year_wrap || tick_overrun || ({day, month, year} !== prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %0d/%0d/%0d done=%b err=%b wrap=%b ovr=%b rdy=%b",
                   day, month, year, set_done, set_err, year_wrap, tick_overrun, set_ready);
        end else begin
          exp_ev = exp_q.pop_front();
          if (act_ev !== exp_ev) begin
            errors++;
            $display("FAIL event: got %0d/%0d/%0d done=%b err=%b wrap=%b ovr=%b rdy=%b, expected %0d/%0d/%0d done=%b err=%b wrap=%b ovr=%b rdy=%b",
                     day, month, year, set_done, set_err, year_wrap, tick_overrun, set_ready,
                     exp_ev.d, exp_ev.m, exp_ev.y, exp_ev.done, exp_ev.err, exp_ev.wrap,
                     exp_ev.ovr, exp_ev.rdy);
          end
        end
      end
      prev = {day, month, year};
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!set_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!set_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got set_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic load(input int d, input int m, input int y, input ev_t e);
    wait_ready();
    exp_q.push_back(e);
    set_valid = 1'b1;
    set_day   = 5'(d);
    set_month = 4'(m);
    set_year  = 10'(y);
    @(negedge clk);
    set_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tick(input ev_t e);
    exp_q.push_back(e);
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_day", 32'(day), 1);
    chk("rst_month", 32'(month), 1);
    chk("rst_year", 32'(year), 0);
    chk("rst_ready", 32'(set_ready), 1);
    chk("rst_flags", {28'd0, set_done, set_err, year_wrap, tick_overrun}, 0);
    prev   = {day, month, year};
    mon_en = 1'b1;
    @(negedge clk);

    // 2028 leap February
    load(28, 2, 3, mk(28, 2, 3, 1, 0, 0, 0, 1));
    tick(mk(29, 2, 3, 0, 0, 0, 0, 1));
    tick(mk(1, 3, 3, 0, 0, 0, 0, 1));
    // 2100 is not leap, 2400 is
    load(28, 2, 75, mk(28, 2, 75, 1, 0, 0, 0, 1));
    tick(mk(1, 3, 75, 0, 0, 0, 0, 1));
    load(28, 2, 375, mk(28, 2, 375, 1, 0, 0, 0, 1));
    tick(mk(29, 2, 375, 0, 0, 0, 0, 1));
    // wrap past YEAR_MAX
    load(31, 12, 974, mk(31, 12, 974, 1, 0, 0, 0, 1));
    tick(mk(1, 1, 0, 0, 0, 1, 0, 1));
    // clamp and rejects
    load(31, 4, 0, mk(30, 4, 0, 1, 0, 0, 0, 1));
    load(5, 13, 0, mk(30, 4, 0, 0, 1, 0, 0, 1));
    load(0, 3, 0, mk(30, 4, 0, 0, 1, 0, 0, 1));
    load(1, 1, 975, mk(30, 4, 0, 0, 1, 0, 0, 1));
    load(1, 0, 0, mk(30, 4, 0, 0, 1, 0, 0, 1));
    load(30, 2, 0, mk(28, 2, 0, 1, 0, 0, 0, 1));
    tick(mk(1, 3, 0, 0, 0, 0, 0, 1));
    load(31, 12, 5, mk(31, 12, 5, 1, 0, 0, 0, 1));
    tick(mk(1, 1, 6, 0, 0, 0, 0, 1));

    // ticks in CHECK and COMMIT: one deferred, one lost
    wait_ready();
    exp_q.push_back(mk(10, 6, 5, 1, 0, 0, 1, 0));
    exp_q.push_back(mk(11, 6, 5, 0, 0, 0, 0, 1));
    set_valid = 1'b1; set_day = 5'd10; set_month = 4'd6; set_year = 10'd5;
    @(negedge clk);
    set_valid = 1'b0; day_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    day_tick = 1'b0;
    repeat (4) @(negedge clk);

    // deferred tick wins over a simultaneous load request
    wait_ready();
    exp_q.push_back(mk(30, 6, 5, 1, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 7, 5, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1));
    set_valid = 1'b1; set_day = 5'd30; set_month = 4'd6; set_year = 10'd5;
    @(negedge clk);
    set_valid = 1'b0; day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
    @(negedge clk);
    chk("pend_ready_low", 32'(set_ready), 0);
    set_valid = 1'b1; set_day = 5'd1; set_month = 4'd1; set_year = 10'd1;
    @(negedge clk);
    chk("ready_after_pend", 32'(set_ready), 1);
    @(negedge clk);
    set_valid = 1'b0;
    repeat (5) @(negedge clk);

    // reset while in CHECK abandons the load
    wait_ready();
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
    set_valid = 1'b1; set_day = 5'd15; set_month = 4'd8; set_year = 10'd7;
    @(negedge clk);
    set_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ready_after_rst", 32'(set_ready), 1);
    repeat (6) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
